// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Shares the N_CDB common-data-bus broadcast slots among all functional
//   units that want to complete in the current cycle. Grants are computed
//   combinationally from the request vector and registered arbitration state,
//   so a requester learns in the same cycle whether it owns a slot.
//
//   Requesters are ranked into one candidate list:
//     1. starved requesters (denied STARVE_LIMIT cycles in a row), by index
//     2. priority-class requesters (PRIO_MASK=1), in rotation order from rr_ptr
//     3. all other requesters, in the same rotation order
//   Slot k receives the k-th candidate. The rotation pointer advances past the
//   requester placed in the highest filled slot, and per-requester saturating
//   counters bound how long anyone can be denied.
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-low reset
//   flush        in   synchronous squash: no grants this cycle, state cleared
//   req          in   [NUM_REQ]         requester i wants a slot this cycle
//   gnt_bus      out  [N_CDB][NUM_REQ]  gnt_bus[k] one-hot owner of slot k, or 0
//   granted      out  [NUM_REQ]         OR of gnt_bus over all slots
//   stall        out  [NUM_REQ]         req & ~granted (backpressure)
//   num_granted  out  [clog2(N_CDB+1)]  number of filled slots
//   rr_ptr       out  [clog2(NUM_REQ)]  current rotation start
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int                 N_CDB        = 2,
  parameter int                 NUM_REQ      = 6,
  parameter logic [NUM_REQ-1:0] PRIO_MASK    = 6'b110000,
  parameter int                 STARVE_LIMIT = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req,
  output logic [N_CDB-1:0][NUM_REQ-1:0] gnt_bus,
  output logic [NUM_REQ-1:0]            granted,
  output logic [NUM_REQ-1:0]            stall,
  output logic [$clog2(N_CDB+1)-1:0]    num_granted,
  output logic [$clog2(NUM_REQ)-1:0]    rr_ptr
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int GW = $clog2(N_CDB + 1);
  // Sort key: 2-bit class in the MSBs, rank within the class below it.
  localparam int KW = PW + 2;

  localparam logic [1:0] CLS_STARVED = 2'd0;
  localparam logic [1:0] CLS_PRIO    = 2'd1;
  localparam logic [1:0] CLS_OTHER   = 2'd2;

  // Distance of requester idx from the rotation start, modulo NUM_REQ.
  function automatic logic [PW-1:0] f_rot_dist(input int idx, input logic [PW-1:0] ptr);
    int p;
    p = int'(ptr);
    return PW'((idx >= p) ? (idx - p) : (idx + NUM_REQ - p));
  endfunction

  // Saturating increment of a starvation counter.
  function automatic logic [SW-1:0] f_sat_inc(input logic [SW-1:0] cnt);
    return (cnt == SW'(STARVE_LIMIT)) ? cnt : cnt + 1'b1;
  endfunction

  // Registered arbitration state
  logic [PW-1:0]              r_rr_ptr;
  logic [NUM_REQ-1:0][SW-1:0] r_starve_cnt;

  // Combinational arbitration
  logic [NUM_REQ-1:0]            w_starved;
  logic [KW-1:0]                 w_key [NUM_REQ];
  logic [PW-1:0]                 w_pos [NUM_REQ];
  logic [N_CDB-1:0][NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0]            w_granted;
  logic [GW-1:0]                 w_num;
  logic [PW-1:0]                 w_last;
  logic [PW-1:0]                 w_last_pos;
  logic                          w_any;
  logic                          w_live;
  logic [PW-1:0]                 w_next_ptr;

  // Every requester gets a unique sort key: indices are unique inside the
  // starved class and rotation distances are unique inside the other two.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_starved[i] = req[i] && (r_starve_cnt[i] == SW'(STARVE_LIMIT));
      if (w_starved[i]) begin
        w_key[i] = {CLS_STARVED, PW'(i)};
      end else if (PRIO_MASK[i]) begin
        w_key[i] = {CLS_PRIO, f_rot_dist(i, r_rr_ptr)};
      end else begin
        w_key[i] = {CLS_OTHER, f_rot_dist(i, r_rr_ptr)};
      end
    end
  end

  // Position in the candidate list = number of active requesters ranked ahead.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pos[i] = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j != i && req[j] && (w_key[j] < w_key[i])) begin
          w_pos[i] = w_pos[i] + 1'b1;
        end
      end
    end
  end

  // Slot k goes to the requester at list position k; positions past the last
  // slot simply receive nothing, which caps the fill at min(N_CDB, popcount).
  always_comb begin
    w_gnt = '0;
    for (int k = 0; k < N_CDB; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (k < NUM_REQ) begin
          w_gnt[k][i] = req[i] && (w_pos[i] == PW'(k));
        end
      end
    end
  end

  always_comb begin
    w_granted = '0;
    for (int k = 0; k < N_CDB; k++) begin
      w_granted = w_granted | w_gnt[k];
    end
  end

  // Fill count and the owner of the highest filled slot (largest position).
  always_comb begin
    w_num      = '0;
    w_any      = 1'b0;
    w_last     = '0;
    w_last_pos = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_granted[i]) begin
        w_num = w_num + 1'b1;
        if (!w_any || (w_pos[i] > w_last_pos)) begin
          w_last     = PW'(i);
          w_last_pos = w_pos[i];
        end
        w_any = 1'b1;
      end
    end
  end

  assign w_next_ptr = (w_last == PW'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;

  // Outputs are gated directly by reset so they drop the moment reset asserts,
  // not at the next clock edge.
  assign w_live      = reset && !flush;
  assign gnt_bus     = w_live ? w_gnt : '0;
  assign granted     = w_live ? w_granted : '0;
  assign num_granted = w_live ? w_num : '0;
  assign stall       = reset ? (req & ~granted) : '0;
  assign rr_ptr      = r_rr_ptr;

  // State update
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr     <= '0;
      r_starve_cnt <= '0;
    end else if (flush) begin
      r_rr_ptr     <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_any) begin
        r_rr_ptr <= w_next_ptr;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && !w_granted[i]) begin
          r_starve_cnt[i] <= f_sat_inc(r_starve_cnt[i]);
        end else begin
          r_starve_cnt[i] <= '0;
        end
      end
    end
  end

  // Structural invariants of the grant outputs
  a_granted_subset : assert property (@(posedge clock) disable iff (!reset)
    (granted & ~req) == '0);
  a_stall_disjoint : assert property (@(posedge clock) disable iff (!reset)
    (stall & granted) == '0);
  a_num_bound      : assert property (@(posedge clock) disable iff (!reset)
    num_granted <= GW'(N_CDB));

  for (genvar k = 0; k < N_CDB; k++) begin : g_slot_chk
    a_slot_onehot : assert property (@(posedge clock) disable iff (!reset)
      $onehot0(gnt_bus[k]));
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps
module tb_cdb_arbiter;

  localparam int         N_CDB        = 2;
  localparam int         NUM_REQ      = 6;
  localparam int         STARVE_LIMIT = 3;
  localparam logic [5:0] PRIO_MASK    = 6'b110000;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic [5:0]      req   = '0;
  logic [1:0][5:0] gnt_bus;
  logic [5:0]      granted;
  logic [5:0]      stall;
  logic [1:0]      num_granted;
  logic [2:0]      rr_ptr;

  cdb_arbiter #(
    .N_CDB       (N_CDB),
    .NUM_REQ     (NUM_REQ),
    .PRIO_MASK   (PRIO_MASK),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .req        (req),
    .gnt_bus    (gnt_bus),
    .granted    (granted),
    .stall      (stall),
    .num_granted(num_granted),
    .rr_ptr     (rr_ptr)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: rotation start and consecutive-denial counts.
  int m_ptr = 0;
  int m_cnt [NUM_REQ] = '{default: 0};

  // Expected outputs for the current inputs and reference state.
  logic [1:0][5:0] e_gnt;
  logic [5:0]      e_granted;
  logic [5:0]      e_stall;
  int              e_num;
  int              e_last;

  bit cmp_en = 1'b0;

  logic [5:0] tbl [8] = '{6'b101010, 6'b010101, 6'b110000, 6'b000011,
                          6'b111110, 6'b100001, 6'b011100, 6'b000000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Candidate list: starved by index, then priority class in rotation order,
  // then the rest in rotation order; the first N_CDB entries own the slots.
  function automatic void compute_expected();
    int cand[$];
    int idx;
    e_gnt     = '0;
    e_granted = '0;
    e_stall   = '0;
    e_num     = 0;
    e_last    = 0;
    if (!reset) return;
    for (int i = 0; i < NUM_REQ; i++)
      if (req[i] && m_cnt[i] == STARVE_LIMIT) cand.push_back(i);
    for (int pass = 0; pass < 2; pass++)
      for (int j = 0; j < NUM_REQ; j++) begin
        idx = (m_ptr + j) % NUM_REQ;
        if (req[idx] && m_cnt[idx] != STARVE_LIMIT && (PRIO_MASK[idx] == (pass == 0)))
          cand.push_back(idx);
      end
    for (int k = 0; k < cand.size() && k < N_CDB; k++) begin
      e_gnt[k][cand[k]]    = 1'b1;
      e_granted[cand[k]]   = 1'b1;
      e_last               = cand[k];
      e_num++;
    end
    if (flush) begin
      e_gnt     = '0;
      e_granted = '0;
      e_num     = 0;
    end
    e_stall = req & ~e_granted;
  endfunction

  // Reference state update
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ptr = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      compute_expected();
      if (flush) begin
        m_ptr = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
      end else begin
        if (e_num > 0) m_ptr = (e_last + 1) % NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req[i] && !e_granted[i])
            m_cnt[i] = (m_cnt[i] < STARVE_LIMIT) ? m_cnt[i] + 1 : STARVE_LIMIT;
          else
            m_cnt[i] = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the reference
  always @(negedge clock) begin
    if (cmp_en) begin
      compute_expected();
      check("model_gnt_bus", 32'(gnt_bus), 32'(e_gnt));
      check("model_granted", 32'(granted), 32'(e_granted));
      check("model_stall", 32'(stall), 32'(e_stall));
      check("model_num_granted", 32'(num_granted), 32'(e_num));
      check("model_rr_ptr", 32'(rr_ptr), 32'(m_ptr));
    end
  end

  task automatic step(input logic [5:0] r, input logic f);
    @(posedge clock);
    #1;
    req   = r;
    flush = f;
    @(negedge clock);
  endtask

  initial begin
    reset  = 1'b0;
    req    = 6'b000111;
    cmp_en = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_gnt_bus", 32'(gnt_bus), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_num", 32'(num_granted), 32'h0);
    check("rst_ptr", 32'(rr_ptr), 32'h0);

    // Release with req 000111 from rr_ptr 0
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("tp1_slot0", 32'(gnt_bus[0]), 32'h01);
    check("tp1_slot1", 32'(gnt_bus[1]), 32'h02);
    check("tp1_stall", 32'(stall), 32'h04);
    check("tp1_num", 32'(num_granted), 32'h2);

    // Same request from rr_ptr 2: wraps to requester 0
    step(6'b000111, 1'b0);
    check("tp2_ptr", 32'(rr_ptr), 32'h2);
    check("tp2_slot0", 32'(gnt_bus[0]), 32'h04);
    check("tp2_slot1", 32'(gnt_bus[1]), 32'h01);

    // Flush with everyone requesting
    step(6'b111111, 1'b1);
    check("flush_gnt_bus", 32'(gnt_bus), 32'h0);
    check("flush_stall", 32'(stall), 32'h3f);
    check("flush_num", 32'(num_granted), 32'h0);

    // Priority class wins until requester 0 starves
    step(6'b110001, 1'b0);
    check("starve_c1_ptr", 32'(rr_ptr), 32'h0);
    check("starve_c1_slot0", 32'(gnt_bus[0]), 32'h10);
    check("starve_c1_slot1", 32'(gnt_bus[1]), 32'h20);
    step(6'b110001, 1'b0);
    check("starve_c2_stall", 32'(stall), 32'h01);
    step(6'b110001, 1'b0);
    check("starve_c3_stall", 32'(stall), 32'h01);
    step(6'b110001, 1'b0);
    check("starve_c4_slot0", 32'(gnt_bus[0]), 32'h01);
    check("starve_c4_slot1", 32'(gnt_bus[1]), 32'h10);
    check("starve_c4_stall", 32'(stall), 32'h20);

    // Single requester
    step(6'b001000, 1'b0);
    check("single_ptr", 32'(rr_ptr), 32'h5);
    check("single_slot0", 32'(gnt_bus[0]), 32'h08);
    check("single_slot1", 32'(gnt_bus[1]), 32'h00);
    check("single_num", 32'(num_granted), 32'h1);

    // Idle cycle
    step(6'b000000, 1'b0);
    check("idle_ptr", 32'(rr_ptr), 32'h4);
    check("idle_gnt_bus", 32'(gnt_bus), 32'h0);

    // Sustained overload: more starved requesters than slots
    for (int c = 0; c < 12; c++) step(6'b111111, 1'b0);

    // Mixed request patterns
    for (int t = 0; t < 8; t++) step(tbl[t], 1'b0);
    for (int t = 0; t < 8; t++) step(tbl[7 - t] | 6'b000001, 1'b0);

    // Asynchronous reset between edges while grants are active
    step(6'b111111, 1'b0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_gnt_bus", 32'(gnt_bus), 32'h0);
    check("async_granted", 32'(granted), 32'h0);
    check("async_stall", 32'(stall), 32'h0);
    check("async_num", 32'(num_granted), 32'h0);
    check("async_ptr", 32'(rr_ptr), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_ptr", 32'(rr_ptr), 32'h0);
    check("post_rst_slot0", 32'(gnt_bus[0]), 32'h10);
    check("post_rst_slot1", 32'(gnt_bus[1]), 32'h20);

    step(6'b000000, 1'b0);
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
